// File: rtl/morse_symbol_decoder.sv
// morse_symbol_decoder
//   Debounces a raw Morse key, classifies each press as dot or dash, groups
//   elements into a symbol ended by a long release gap, and decodes the
//   symbol to a hex digit for the display shift stage.
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   key    raw key, active-high, asynchronous, bouncy
//   code   hex value of the last valid symbol (held until the next one)
//   flag   one-cycle strobe: code is new this cycle
//   err    one-cycle strobe: the symbol just ended was not a legal pattern
//   elems  elements accumulated in the current symbol (0-5)
//   busy   symbol in progress (PRESS or GAP)
module morse_symbol_decoder #(
  parameter int DEBOUNCE_CYC   = 100000,
  parameter int DOT_MAX_CYC    = 20000000,
  parameter int LETTER_GAP_CYC = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  output logic [3:0] code,
  output logic       flag,
  output logic       err,
  output logic [2:0] elems,
  output logic       busy
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int PR_W = $clog2(DOT_MAX_CYC + 1);
  localparam int GP_W = $clog2(LETTER_GAP_CYC + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PR_W-1:0] DOT_MAX  = PR_W'(DOT_MAX_CYC);
  localparam logic [GP_W-1:0] GAP_LAST = GP_W'(LETTER_GAP_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_EMIT  = 2'd3;

  // Returns {valid, hex}. Patterns shorter than five elements keep their
  // unused upper bits at zero, so the length plus the pattern is unique.
  function automatic logic [4:0] decode(input logic [2:0] n, input logic [4:0] p);
    case ({n, p})
      {3'd5, 5'b11111}: decode = {1'b1, 4'h0};
      {3'd5, 5'b01111}: decode = {1'b1, 4'h1};
      {3'd5, 5'b00111}: decode = {1'b1, 4'h2};
      {3'd5, 5'b00011}: decode = {1'b1, 4'h3};
      {3'd5, 5'b00001}: decode = {1'b1, 4'h4};
      {3'd5, 5'b00000}: decode = {1'b1, 4'h5};
      {3'd5, 5'b10000}: decode = {1'b1, 4'h6};
      {3'd5, 5'b11000}: decode = {1'b1, 4'h7};
      {3'd5, 5'b11100}: decode = {1'b1, 4'h8};
      {3'd5, 5'b11110}: decode = {1'b1, 4'h9};
      {3'd2, 5'b00001}: decode = {1'b1, 4'hA};
      {3'd4, 5'b01000}: decode = {1'b1, 4'hB};
      {3'd4, 5'b01010}: decode = {1'b1, 4'hC};
      {3'd3, 5'b00100}: decode = {1'b1, 4'hD};
      {3'd1, 5'b00000}: decode = {1'b1, 4'hE};
      {3'd4, 5'b00010}: decode = {1'b1, 4'hF};
      default:          decode = {1'b0, 4'h0};
    endcase
  endfunction

  logic            key_p0, key_p1;
  logic [DB_W-1:0] db_cnt;
  logic            kd;
  logic [1:0]      state;
  logic [PR_W-1:0] press_cnt;
  logic [GP_W-1:0] gap_cnt;
  logic [4:0]      pat;
  logic [2:0]      len;
  logic            ovf;
  logic [4:0]      dec;

  assign dec   = decode(len, pat);
  assign elems = len;
  assign busy  = (state == S_PRESS) || (state == S_GAP);

  // Stage p0/p1: two-flop synchroniser for the asynchronous key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= 1'b0;
      key_p1 <= 1'b0;
    end else begin
      key_p0 <= key;
      key_p1 <= key_p0;
    end
  end

  // Debounce: kd flips only after key_p1 has disagreed for DEBOUNCE_CYC cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      kd     <= 1'b0;
    end else if (key_p1 != kd) begin
      if (db_cnt == DB_LAST) begin
        kd     <= key_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Symbol FSM, element accumulation and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      press_cnt <= '0;
      gap_cnt   <= '0;
      pat       <= '0;
      len       <= '0;
      ovf       <= 1'b0;
      code      <= '0;
      flag      <= 1'b0;
      err       <= 1'b0;
    end else begin
      flag <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          // Level test: a key still held after EMIT starts the next symbol.
          // The cycle seen here is the first high cycle of the press.
          if (kd) begin
            state     <= S_PRESS;
            press_cnt <= PR_W'(1);
          end
        end
        S_PRESS: begin
          if (!kd) begin
            state   <= S_GAP;
            gap_cnt <= GP_W'(1);
            if (len == 3'd5) begin
              ovf <= 1'b1;
            end else begin
              pat <= {pat[3:0], (press_cnt >= DOT_MAX)};
              len <= len + 1'b1;
            end
          end else if (press_cnt != DOT_MAX) begin
            press_cnt <= press_cnt + 1'b1;
          end
        end
        S_GAP: begin
          // A new press wins over the timeout on the last gap cycle.
          if (kd) begin
            state     <= S_PRESS;
            press_cnt <= PR_W'(1);
            gap_cnt   <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            if (gap_cnt == GAP_LAST) begin
              state <= S_EMIT;
            end
          end
        end
        default: begin
          if (dec[4] && !ovf) begin
            flag <= 1'b1;
            code <= dec[3:0];
          end else begin
            err <= 1'b1;
          end
          pat       <= '0;
          len       <= '0;
          ovf       <= 1'b0;
          press_cnt <= '0;
          gap_cnt   <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_symbol_decoder.sv
module tb_morse_symbol_decoder;

  localparam int DB  = 4;
  localparam int DM  = 20;
  localparam int LG  = 50;
  // key release -> strobe: 2 sync + DB debounce + LG gap + 1 output register
  localparam int LAT = DB + LG + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key = 1'b0;
  logic [3:0] code;
  logic       flag;
  logic       err;
  logic [2:0] elems;
  logic       busy;

  morse_symbol_decoder #(
    .DEBOUNCE_CYC  (DB),
    .DOT_MAX_CYC   (DM),
    .LETTER_GAP_CYC(LG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .key  (key),
    .code (code),
    .flag (flag),
    .err  (err),
    .elems(elems),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int flag_cnt = 0;
  int err_cnt = 0;
  int last_strobe_cyc = 0;
  int rel_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor: counts pulses, timestamps them, and checks exclusivity
  always @(negedge clk) begin
    if (flag || err) begin
      check("strobe_exclusive", 32'(flag & err), 32'd0);
      if (flag) flag_cnt++;
      if (err) err_cnt++;
      last_strobe_cyc = cyc;
    end
  end

  // Called on a negedge; key high for exactly n cycles, returns on a negedge
  task automatic press(input int n);
    key = 1'b1;
    repeat (n) @(negedge clk);
    key = 1'b0;
    rel_cyc = cyc;
  endtask

  typedef struct {
    int         nel;
    logic [5:0] pat;      // 1 = dash, earliest element at bit nel-1
    int         dot_len;
    int         dash_len;
    int         gap;
    bit         ev;       // expect flag (1) or err (0)
    logic [3:0] ec;       // expected code after the symbol
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input vec_t v, input int idx);
    int f0;
    int e0;
    f0 = flag_cnt;
    e0 = err_cnt;
    for (int i = v.nel - 1; i >= 0; i--) begin
      press(v.pat[i] ? v.dash_len : v.dot_len);
      if (i > 0) repeat (v.gap) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check($sformatf("v%0d_elems", idx), 32'(elems), (v.nel > 5) ? 32'd5 : 32'(v.nel));
    check($sformatf("v%0d_busy_mid", idx), 32'(busy), 32'd1);
    repeat (50) @(negedge clk);
    check($sformatf("v%0d_flag_pulses", idx), 32'(flag_cnt - f0), v.ev ? 32'd1 : 32'd0);
    check($sformatf("v%0d_err_pulses", idx), 32'(err_cnt - e0), v.ev ? 32'd0 : 32'd1);
    check($sformatf("v%0d_code", idx), 32'(code), 32'(v.ec));
    check($sformatf("v%0d_latency", idx), 32'(last_strobe_cyc - rel_cyc), 32'(LAT));
    check($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d_elems_end", idx), 32'(elems), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int e0;
    bit bad;

    vecs[0]  = '{2, 6'b000001, 10, 30, 15, 1'b1, 4'hA};  // .-
    vecs[1]  = '{5, 6'b011111, 10, 20, 15, 1'b1, 4'h0};  // ----- at exact dash length
    vecs[2]  = '{5, 6'b000000, 19, 30, 15, 1'b1, 4'h5};  // ..... at longest dot
    vecs[3]  = '{4, 6'b001000, 10, 30, 15, 1'b1, 4'hB};  // -...
    vecs[4]  = '{4, 6'b001010, 10, 30, 15, 1'b1, 4'hC};  // -.-.
    vecs[5]  = '{3, 6'b000100, 10, 30, 15, 1'b1, 4'hD};  // -..
    vecs[6]  = '{4, 6'b000010, 10, 30, 15, 1'b1, 4'hF};  // ..-.
    vecs[7]  = '{5, 6'b011000, 10, 30, 15, 1'b1, 4'h7};  // --...
    vecs[8]  = '{6, 6'b000000, 10, 30, 15, 1'b0, 4'h7};  // six dots: overflow
    vecs[9]  = '{2, 6'b000011, 10, 30, 15, 1'b0, 4'h7};  // -- : illegal
    vecs[10] = '{2, 6'b000001, 10, 30, 49, 1'b1, 4'hA};  // .- with gap at LG-1
    vecs[11] = '{5, 6'b011110, 10, 30, 15, 1'b1, 4'h9};  // ----.

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {24'd0, code, flag, err, elems, busy}, 32'd0);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ({code, flag, err, elems, busy} != 10'd0) bad = 1'b1;
    end
    check("idle_200_outputs_zero", 32'(bad), 32'd0);

    // Table-driven symbols
    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Glitches shorter than the debounce window never start a symbol
    f0 = flag_cnt;
    e0 = err_cnt;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key = 1'b1;
      repeat (3) @(negedge clk);
      if (busy || elems != 3'd0) bad = 1'b1;
      key = 1'b0;
      repeat (3) @(negedge clk);
      if (busy || elems != 3'd0) bad = 1'b1;
    end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy || elems != 3'd0) bad = 1'b1;
    end
    check("bounce_no_activity", 32'(bad), 32'd0);
    check("bounce_no_strobe", 32'((flag_cnt - f0) + (err_cnt - e0)), 32'd0);
    check("bounce_code_held", 32'(code), 32'h9);

    // Reset in GAP after .- discards the symbol
    f0 = flag_cnt;
    e0 = err_cnt;
    press(10);
    repeat (15) @(negedge clk);
    press(30);
    repeat (20) @(negedge clk);
    check("gap_busy_before_reset", 32'(busy), 32'd1);
    check("gap_elems_before_reset", 32'(elems), 32'd2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_outputs", {24'd0, code, flag, err, elems, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("midreset_no_strobe", 32'((flag_cnt - f0) + (err_cnt - e0)), 32'd0);

    // Next symbol '.' decodes to E with the standard latency
    f0 = flag_cnt;
    e0 = err_cnt;
    press(10);
    repeat (70) @(negedge clk);
    check("e_flag_pulses", 32'(flag_cnt - f0), 32'd1);
    check("e_err_pulses", 32'(err_cnt - e0), 32'd0);
    check("e_code", 32'(code), 32'hE);
    check("e_latency", 32'(last_strobe_cyc - rel_cyc), 32'(LAT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
